// File: rtl/pll_lock_sequencer.sv
// Holds the core in reset until the PLL has been locked for STABLE_CYCLES clocks,
// then emits two half-period-offset CPU clock-enable pulses and flags lock loss.
module pll_lock_sequencer #(
    parameter int STABLE_CYCLES = 4096,
    parameter int DIVIDER       = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic run,
    input  logic lock_lost_clr,
    output logic core_reset_n,
    output logic ce_cpu,
    output logic ce_cpu_n,
    output logic lock_lost
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int DW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(DIVIDER - 1);
    localparam logic [DW-1:0] DIV_HALF    = DW'(DIVIDER / 2 - 1);

    typedef enum logic [1:0] {WAIT, STABLE, RUN} state_t;

    state_t        state;
    logic          sync1;
    logic          locked_s;
    logic [SW-1:0] stable_cnt;
    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT;
            sync1        <= 1'b0;
            locked_s     <= 1'b0;
            stable_cnt   <= '0;
            div_cnt      <= '0;
            core_reset_n <= 1'b0;
            ce_cpu       <= 1'b0;
            ce_cpu_n     <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
            ce_cpu   <= 1'b0;
            ce_cpu_n <= 1'b0;
            // Clear first so a same-cycle lock loss below overrides it.
            if (lock_lost_clr) lock_lost <= 1'b0;
            case (state)
                WAIT: begin
                    core_reset_n <= 1'b0;
                    stable_cnt   <= '0;
                    div_cnt      <= '0;
                    if (locked_s) state <= STABLE;
                end
                STABLE: begin
                    if (!locked_s) begin
                        state      <= WAIT;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state        <= RUN;
                        core_reset_n <= 1'b1;
                        stable_cnt   <= '0;
                        div_cnt      <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state        <= WAIT;
                        core_reset_n <= 1'b0;
                        div_cnt      <= '0;
                        lock_lost    <= 1'b1;
                    end else if (run) begin
                        ce_cpu   <= (div_cnt == DIV_LAST);
                        ce_cpu_n <= (div_cnt == DIV_HALF);
                        div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (STABLE_CYCLES=8, DIVIDER=10); ce pulses
// are checked against a queue of expected (kind, edge) events.
module tb_pll_lock_sequencer;

    logic clk = 1'b0;
    logic reset_n, pll_locked, run, lock_lost_clr;
    logic core_reset_n, ce_cpu, ce_cpu_n, lock_lost;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        bit kind;  // 1 = ce_cpu, 0 = ce_cpu_n
        int edge_i;
    } ev_t;
    ev_t exp_q[$];

    pll_lock_sequencer #(.STABLE_CYCLES(8), .DIVIDER(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .run          (run),
        .lock_lost_clr(lock_lost_clr),
        .core_reset_n (core_reset_n),
        .ce_cpu       (ce_cpu),
        .ce_cpu_n     (ce_cpu_n),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_ev(input bit kind);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL unexpected_pulse: observed kind %0d at edge %0d, expected none", kind, edge_n);
        end else begin
            e = exp_q.pop_front();
            assert (e.kind === kind && e.edge_i === edge_n) else begin
                n_fail++;
                $error("FAIL pulse: observed kind %0d edge %0d expected kind %0d edge %0d",
                       kind, edge_n, e.kind, e.edge_i);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ce_cpu)   check_ev(1'b1);
            if (ce_cpu_n) check_ev(1'b0);
        end
    end

    task automatic push(input bit kind, input int e);
        ev_t ev;
        ev.kind   = kind;
        ev.edge_i = e;
        exp_q.push_back(ev);
    endtask

    task automatic goto(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic queue_drained(input string tag);
        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s: observed %0d pulses missing, expected 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        int b, c, d, e, g, h, r;
        reset_n = 1'b0; pll_locked = 1'b0; run = 1'b0; lock_lost_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_core_reset_n", core_reset_n, 1'b0);
        chk("rst_ce_cpu", ce_cpu, 1'b0);
        chk("rst_ce_cpu_n", ce_cpu_n, 1'b0);
        chk("rst_lock_lost", lock_lost, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_core_reset_n", core_reset_n, 1'b0);

        // Lock-up: release at +10, ce_cpu_n at +15, ce_cpu at +20, period 10
        pll_locked = 1'b1; run = 1'b1;
        b = edge_n + 1;
        for (int k = 0; k < 3; k++) begin
            push(1'b0, b + 15 + 10 * k);
            push(1'b1, b + 20 + 10 * k);
        end
        mon_en = 1'b1;
        goto(b + 9);
        chk("lock_crn_before", core_reset_n, 1'b0);
        goto(b + 10);
        chk("lock_crn_release", core_reset_n, 1'b1);
        goto(b + 41);
        queue_drained("lock_pulses");

        // Pause for 7 cycles with divider at 3
        goto(b + 43);
        run = 1'b0;
        goto(b + 50);
        run = 1'b1;
        c = b + 51;
        push(1'b0, c + 1);
        push(1'b1, c + 6);
        push(1'b0, c + 11);
        push(1'b1, c + 16);
        goto(c + 17);
        mon_en = 1'b0;
        queue_drained("pause_pulses");

        // Lock loss with coincident clear: set wins
        pll_locked = 1'b0;
        d = edge_n + 1;
        goto(d + 1);
        chk("loss_crn_pre", core_reset_n, 1'b1);
        chk("loss_ll_pre", lock_lost, 1'b0);
        lock_lost_clr = 1'b1;
        goto(d + 2);
        lock_lost_clr = 1'b0;
        chk("loss_crn", core_reset_n, 1'b0);
        chk("loss_ll_set_wins", lock_lost, 1'b1);
        chk("loss_ce_cpu", ce_cpu, 1'b0);
        chk("loss_ce_cpu_n", ce_cpu_n, 1'b0);
        goto(d + 5);
        chk("loss_crn_hold", core_reset_n, 1'b0);

        // Relock: release after 2+8 cycles, divider restarts, lock_lost sticky
        pll_locked = 1'b1;
        e = edge_n + 1;
        push(1'b0, e + 15);
        push(1'b1, e + 20);
        mon_en = 1'b1;
        goto(e + 9);
        chk("relock_crn_before", core_reset_n, 1'b0);
        goto(e + 10);
        chk("relock_crn", core_reset_n, 1'b1);
        goto(e + 21);
        mon_en = 1'b0;
        queue_drained("relock_pulses");
        chk("relock_ll_sticky", lock_lost, 1'b1);
        lock_lost_clr = 1'b1;
        @(negedge clk);
        lock_lost_clr = 1'b0;
        chk("ll_cleared", lock_lost, 1'b0);

        // Second loss without clear, relock, then async reset mid-RUN
        pll_locked = 1'b0;
        g = edge_n + 1;
        goto(g + 2);
        chk("loss2_ll", lock_lost, 1'b1);
        pll_locked = 1'b1;
        h = edge_n + 1;
        goto(h + 10);
        chk("loss2_relock_crn", core_reset_n, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_crn", core_reset_n, 1'b0);
        chk("arst_ce_cpu", ce_cpu, 1'b0);
        chk("arst_ce_cpu_n", ce_cpu_n, 1'b0);
        chk("arst_ll", lock_lost, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // One-cycle glitch while stable count is 5: full recount
        r = edge_n + 1;
        goto(r + 5);
        pll_locked = 1'b0;
        goto(r + 6);
        pll_locked = 1'b1;
        goto(r + 10);
        chk("glitch_crn_nominal", core_reset_n, 1'b0);
        goto(r + 16);
        chk("glitch_crn_before", core_reset_n, 1'b0);
        goto(r + 17);
        chk("glitch_crn_release", core_reset_n, 1'b1);
        chk("glitch_ll", lock_lost, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4096: consecutive synchronized-lock cycles required before core reset release; legal range 2..65535.
REQ-002 SHALL have parameter DIVIDER, default 1000: clk cycles per CPU clock-enable period (32.768 MHz / 1000 = 32.768 kHz); even values only, legal range 4..65535.
REQ-003 SHALL have port clk  input  1  system clock, the 32.768 MHz PLL output; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pll_locked  input  1  PLL lock indicator, asynchronous to clk.
REQ-006 SHALL have port run  input  1  1 = CPU enables advance, 0 = pause (divider holds).
REQ-007 SHALL have port lock_lost_clr  input  1  single-cycle clear of lock_lost.
REQ-008 SHALL have port core_reset_n  output  1  registered active-low reset to the core.
REQ-009 SHALL have port ce_cpu  output  1  single-cycle CPU clock-enable pulse.
REQ-010 SHALL have port ce_cpu_n  output  1  single-cycle pulse offset half a period from ce_cpu.
REQ-011 SHALL have port lock_lost  output  1  sticky flag: lock dropped while in RUN.

Function
REQ-012 SHALL synchronize pll_locked through two flops into locked_s; no other logic uses pll_locked directly.
REQ-013 SHALL implement FSM states WAIT, STABLE, RUN.
REQ-014 WAIT: core_reset_n=0, ce outputs 0, stable counter 0; locked_s=1 -> STABLE.
REQ-015 STABLE: stable counter increments each cycle; locked_s=0 -> WAIT with counter cleared; counter==STABLE_CYCLES-1 with locked_s=1 -> RUN.
REQ-016 RUN: core_reset_n=1, registered, asserted high the first cycle the FSM is in RUN.
REQ-017 RUN: divider counter starts at 0 on RUN entry, increments by 1 when run=1, wraps DIVIDER-1 -> 0, holds when run=0.
REQ-018 ce_cpu SHALL be 1 for exactly one cycle when run=1 and divider==DIVIDER-1; ce_cpu_n likewise when divider==DIVIDER/2-1; both registered; never 1 when run=0 or outside RUN.
REQ-019 RUN with locked_s=0 SHALL go to WAIT; core_reset_n and ce outputs SHALL be 0 the next cycle; divider cleared.
REQ-020 lock_lost SHALL set on the RUN -> WAIT transition and clear on lock_lost_clr; simultaneous set and clear -> set wins.
REQ-021 lock drop in STABLE or WAIT SHALL NOT set lock_lost.
REQ-022 Counters SHALL be sized to hold the parameter maxima without overflow; no wrap other than REQ-017.

Reset
REQ-023 reset_n=0 SHALL asynchronously force: FSM=WAIT, synchronizer flops 0, all counters 0, core_reset_n=0, ce_cpu=0, ce_cpu_n=0, lock_lost=0.
REQ-024 Deassertion of reset_n SHALL resume from WAIT; reset asserted mid-RUN behaves as REQ-023 and does not set lock_lost.

Verification (STABLE_CYCLES=8, DIVIDER=10)
REQ-025 pll_locked rises at cycle 0, run=1 -> locked_s at cycle 2, core_reset_n=1 at cycle 10, first ce_cpu_n at cycle 15, first ce_cpu at cycle 20, then every 10 cycles each.
REQ-026 pll_locked glitches low for 1 cycle at count 5 in STABLE -> return to WAIT, full 8-cycle recount, lock_lost stays 0.
REQ-027 In RUN, run=0 for 7 cycles at divider=3 -> no ce pulses, divider holds at 3, resumes with ce_cpu 6 cycles after run returns to 1.
REQ-028 In RUN, pll_locked falls -> core_reset_n=0 and lock_lost=1 three cycles later; relock -> core_reset_n=1 after 2+8 cycles; lock_lost remains 1 until lock_lost_clr.
REQ-029 lock_lost_clr coincident with lock-loss transition -> lock_lost=1.
REQ-030 reset_n pulsed low mid-RUN between clock edges -> all outputs 0 immediately, no clock edge required; lock_lost=0.
